// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the datapath ALU: the 3-bit operation encoding used on
// alu_core.input_aluctr and small helpers for classifying operations.
//
// Contents:
//   alu_op_t       3-bit operation select (ALU_ADDU .. ALU_SLTU)
//   op_uses_sub()  1 when the shared adder must run as a subtractor
//   op_is_signed() 1 for the operations that report signed overflow
//
// Optional feature macro used by the ALU: ALU_OVERFLOW_EN (see alu_core).
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADDU = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUBU = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_t;

  // Subtraction and both compares are all built on A - B.
  function automatic logic op_uses_sub(input alu_op_t op);
    return (op == ALU_SUBU) || (op == ALU_SUB) ||
           (op == ALU_SLT)  || (op == ALU_SLTU);
  endfunction

  // Only the signed add/subtract operations may raise the overflow flag.
  function automatic logic op_is_signed(input alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_adder.sv
// -----------------------------------------------------------------------------
// alu_adder
// n-bit adder/subtractor shared by every arithmetic and compare operation.
// Subtraction is formed as a + ~b + 1 so a single carry chain serves both.
//
// Parameters:
//   n         operand width (n >= 2)
// Ports:
//   a         in  n  first operand
//   b         in  n  second operand
//   sub       in  1  1: compute a - b, 0: compute a + b
//   sum       out n  wrapped result
//   carry     out 1  carry out of the MSB (for a - b: 1 means no borrow)
//   overflow  out 1  two's-complement overflow of the operation performed
// -----------------------------------------------------------------------------
module alu_adder #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sub,
  output logic [n-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic [n-1:0] b_eff;

  // Inverting b and injecting sub as the carry-in gives a + ~b + 1 = a - b.
  assign b_eff = b ^ {n{sub}};

  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, sub};

  // Overflow when the two adder inputs agree in sign but the sum does not.
  // Using b_eff covers both cases: for subtraction this reads "signs of a and
  // b differ and the result sign differs from a".
  assign overflow = (a[n-1] == b_eff[n-1]) && (sum[n-1] != a[n-1]);

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Parameterised integer ALU for the single-cycle datapath. Performs one of
// eight add/subtract/logic/compare operations per clock and registers the
// result together with a zero flag and a signed-overflow flag.
//
// Parameters:
//   n              operand and result width (n >= 2), default 32
// Ports:
//   input_clk      in  1  rising-edge clock
//   input_rst      in  1  asynchronous active-high reset
//   input_a        in  n  operand A
//   input_b        in  n  operand B
//   input_aluctr   in  3  operation select (alu_pkg::alu_op_t encoding)
//   out_result     out n  registered result
//   out_zero       out 1  registered flag: result equals 0
//   out_overflow   out 1  registered signed-overflow flag (ADD/SUB only)
//
// Configuration macro:
//   ALU_OVERFLOW_EN  defined: ADD/SUB report two's-complement overflow.
//                    undefined: out_overflow is constant 0, ADD == ADDU and
//                    SUB == SUBU. SLT stays a correct signed compare either way.
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         input_clk,
  input  logic         input_rst,
  input  logic [n-1:0] input_a,
  input  logic [n-1:0] input_b,
  input  logic [2:0]   input_aluctr,
  output logic [n-1:0] out_result,
  output logic         out_zero,
  output logic         out_overflow
);

  alu_op_t      op;
  logic         sub;
  logic [n-1:0] sum;
  logic         carry;
  logic         add_ovf;
  logic         slt_bit;
  logic         sltu_bit;
  logic [n-1:0] logic_and;
  logic [n-1:0] logic_or;
  logic [n-1:0] result_d;
  logic         zero_d;
  logic         ovf_d;

  assign op  = alu_op_t'(input_aluctr);
  assign sub = op_uses_sub(op);

  // ---------------------------------------------------------------------------
  // Shared adder/subtractor
  // ---------------------------------------------------------------------------
  alu_adder #(
    .n (n)
  ) u_adder (
    .a        (input_a),
    .b        (input_b),
    .sub      (sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (add_ovf)
  );

  // ---------------------------------------------------------------------------
  // Logic unit
  // ---------------------------------------------------------------------------
  assign logic_and = input_a & input_b;
  assign logic_or  = input_a | input_b;

  // ---------------------------------------------------------------------------
  // Compare logic (both driven by the adder running A - B)
  // ---------------------------------------------------------------------------
  // Signed less-than: the sign of A - B is wrong exactly when the subtraction
  // overflowed, so XOR with the overflow recovers the true sign.
  assign slt_bit  = sum[n-1] ^ add_ovf;
  // Unsigned less-than: A - B borrows, i.e. the carry out is clear.
  assign sltu_bit = ~carry;

  // ---------------------------------------------------------------------------
  // Result mux and flags
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path through the
  // case can leave it unassigned and infer a latch.
  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    case (op)
      ALU_ADDU,
      ALU_ADD,
      ALU_SUBU,
      ALU_SUB:  result_d = sum;
      ALU_AND:  result_d = logic_and;
      ALU_OR:   result_d = logic_or;
      ALU_SLT:  result_d = {{(n-1){1'b0}}, slt_bit};
      ALU_SLTU: result_d = {{(n-1){1'b0}}, sltu_bit};
      default:  result_d = '0;
    endcase
`ifdef ALU_OVERFLOW_EN
    // The wrapped sum is still written on overflow; only the flag reports it.
    ovf_d = op_is_signed(op) && add_ovf;
`else
    ovf_d = 1'b0;
`endif
  end

  assign zero_d = (result_d == '0);

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all three outputs
  // update together from values sampled at the same edge.
  always_ff @(posedge input_clk or posedge input_rst) begin
    if (input_rst) begin
      out_result   <= '0;
      out_zero     <= 1'b1;
      out_overflow <= 1'b0;
    end else begin
      out_result   <= result_d;
      out_zero     <= zero_d;
      out_overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core
// Self-checking bench for alu_core (n = 32). Directed vectors with hand-computed
// results are queued as they are driven; a monitor pops and compares them one
// cycle later. Reset behaviour is checked directly in the stimulus process.
// Expected overflow flags follow ALU_OVERFLOW_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_core;
  import alu_pkg::*;

  localparam int N = 32;

`ifdef ALU_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [N-1:0] result;
    logic         ovf;
  } exp_t;

  logic         input_clk;
  logic         input_rst;
  logic [N-1:0] input_a;
  logic [N-1:0] input_b;
  logic [2:0]   input_aluctr;
  logic [N-1:0] out_result;
  logic         out_zero;
  logic         out_overflow;

  logic vec_valid;
  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  alu_core #(
    .n (N)
  ) dut (
    .input_clk    (input_clk),
    .input_rst    (input_rst),
    .input_a      (input_a),
    .input_b      (input_b),
    .input_aluctr (input_aluctr),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
  );

  initial input_clk = 1'b0;
  always #5 input_clk = ~input_clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one operation now and queue its expected response.
  task automatic load(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                      input alu_op_t op, input logic [N-1:0] res, input logic ovf);
    exp_t e;
    input_a      = a;
    input_b      = b;
    input_aluctr = op;
    vec_valid    = 1'b1;
    e.name   = name;
    e.result = res;
    e.ovf    = ovf;
    sb.push_back(e);
  endtask

  task automatic issue(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input alu_op_t op, input logic [N-1:0] res, input logic ovf);
    @(negedge input_clk);
    #1;
    load(name, a, b, op, res, ovf);
  endtask

  // Monitor: every edge that sampled a queued vector is checked at the
  // following falling edge.
  initial begin
    logic took;
    exp_t e;
    forever begin
      @(posedge input_clk);
      took = vec_valid && !input_rst;
      @(negedge input_clk);
      if (took) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: output presented with no expected entry");
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, out_result, e.result);
          check({e.name, "_zero"}, {31'd0, out_zero}, {31'd0, (e.result == '0)});
          check({e.name, "_ovf"}, {31'd0, out_overflow}, {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cycles;
    n_checks     = 0;
    n_fail       = 0;
    vec_valid    = 1'b0;
    input_rst    = 1'b1;
    input_a      = '0;
    input_b      = '0;
    input_aluctr = 3'b000;

    // Reset state is visible without any clock edge.
    #1;
    check("reset_result", out_result, 32'd0);
    check("reset_zero", {31'd0, out_zero}, 32'd1);
    check("reset_ovf", {31'd0, out_overflow}, 32'd0);

    @(negedge input_clk);
    #1;
    input_rst = 1'b0;
    // First edge after release registers this operation.
    load("sweep_addu", 32'd31, 32'd24, ALU_ADDU, 32'd55, 1'b0);
    issue("sweep_add",  32'd31, 32'd24, ALU_ADD,  32'd55, 1'b0);
    issue("sweep_subu", 32'd31, 32'd24, ALU_SUBU, 32'd7,  1'b0);
    issue("sweep_sub",  32'd31, 32'd24, ALU_SUB,  32'd7,  1'b0);
    issue("sweep_and",  32'd31, 32'd24, ALU_AND,  32'd24, 1'b0);
    issue("sweep_or",   32'd31, 32'd24, ALU_OR,   32'd31, 1'b0);
    issue("sweep_slt",  32'd31, 32'd24, ALU_SLT,  32'd0,  1'b0);
    issue("sweep_sltu", 32'd31, 32'd24, ALU_SLTU, 32'd0,  1'b0);

    issue("add_ovf",     32'h7FFF_FFFF, 32'd1, ALU_ADD,  32'h8000_0000, OVF);
    issue("addu_noovf",  32'h7FFF_FFFF, 32'd1, ALU_ADDU, 32'h8000_0000, 1'b0);
    issue("sub_ovf",     32'h8000_0000, 32'd1, ALU_SUB,  32'h7FFF_FFFF, OVF);
    issue("sub_ovf_neg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, ALU_SUB, 32'h8000_0000, OVF);
    issue("add_wrap0",   32'hFFFF_FFFF, 32'd1, ALU_ADD,  32'h0000_0000, 1'b0);
    issue("subu_zero",   32'd5, 32'd5, ALU_SUBU, 32'd0, 1'b0);
    issue("slt_neg",     32'hFFFF_FFFF, 32'd1, ALU_SLT,  32'd1, 1'b0);
    issue("sltu_big",    32'hFFFF_FFFF, 32'd1, ALU_SLTU, 32'd0, 1'b0);
    issue("slt_pos",     32'd1, 32'hFFFF_FFFF, ALU_SLT,  32'd0, 1'b0);
    issue("sltu_small",  32'd1, 32'hFFFF_FFFF, ALU_SLTU, 32'd1, 1'b0);
    issue("slt_ovfpath", 32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'd1, 1'b0);
    issue("and_pat",     32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 32'hF000_F000, 1'b0);
    issue("or_pat",      32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR,  32'hFFF0_FFF0, 1'b0);

    // Inputs changed between edges must not disturb the registered outputs.
    issue("glitch_hold", 32'd100, 32'd58, ALU_SUBU, 32'd42, 1'b0);
    @(posedge input_clk);
    #1;
    vec_valid    = 1'b0;
    input_a      = 32'hDEAD_BEEF;
    input_b      = 32'h1234_5678;
    input_aluctr = ALU_OR;

    // Mid-stream asynchronous reset.
    issue("pre_reset", 32'd31, 32'd24, ALU_ADD, 32'd55, 1'b0);
    @(negedge input_clk);
    #1;
    vec_valid    = 1'b0;
    input_a      = 32'h0000_0003;
    input_b      = 32'h0000_0004;
    input_aluctr = ALU_OR;
    #2;
    check("before_rst_result", out_result, 32'd55);
    input_rst = 1'b1;
    #1;
    check("async_rst_result", out_result, 32'd0);
    check("async_rst_zero", {31'd0, out_zero}, 32'd1);
    check("async_rst_ovf", {31'd0, out_overflow}, 32'd0);
    repeat (2) @(posedge input_clk);
    @(negedge input_clk);
    check("rst_hold_result", out_result, 32'd0);
    check("rst_hold_zero", {31'd0, out_zero}, 32'd1);
    check("rst_hold_ovf", {31'd0, out_overflow}, 32'd0);
    #1;
    input_rst = 1'b0;
    load("post_rst_and", 32'hF0F0_F0F0, 32'h0F0F_FFFF, ALU_AND, 32'h0000_F0F0, 1'b0);
    issue("post_rst_add_ovf", 32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, OVF);

    @(negedge input_clk);
    #1;
    vec_valid = 1'b0;

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 20) begin
      @(negedge input_clk);
      wait_cycles++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
